cpu_core_hs: RTL

CPU_CORE_HS -- requirements
Module: cpu_core_hs

---
 rtl/cpu_core_hs.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_core_hs.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_core_hs
//  Description : Multi-cycle 16-bit-instruction CPU core with handshaked
//                instruction and data buses and a single-level interrupt.
//                Each instruction runs FETCH -> DECODE -> EXEC -> [MEM] -> WB,
//                with an optional IRQ entry state after WB.
//  Ports       : clk_i / reset_i       clock, asynchronous active-high reset
//                ins_addr_o            instruction address (= pc)
//                ins_req_o / ins_ack_i instruction fetch handshake
//                ins_data_i            instruction word, valid with ins_ack_i
//                mem_addr_o            data / port address
//                mem_wdata_o           STORE / OUT data
//                mem_rdata_i           LOAD / IN data, valid with mem_ack_i
//                mem_req_o / mem_ack_i data access handshake
//                mem_we_o              1 = write, 0 = read
//                mem_io_o              1 = port space, 0 = memory space
//                irq_i                 level-sensitive interrupt request
//                irq_ack_o             one-cycle pulse on interrupt entry
//                state_o               current FSM state (debug)
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_core_hs #(
   parameter int                       WORD_SIZE     = 16,
   parameter int                       INS_ADDR_SIZE = 8,
   parameter int                       NUM_REGS      = 16,
   parameter logic [INS_ADDR_SIZE-1:0] IRQ_VECTOR    = 'hF0
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   output logic [INS_ADDR_SIZE-1:0] ins_addr_o,
   output logic                     ins_req_o,
   input  logic                     ins_ack_i,
   input  logic [15:0]              ins_data_i,
   output logic [WORD_SIZE-1:0]     mem_addr_o,
   output logic [WORD_SIZE-1:0]     mem_wdata_o,
   input  logic [WORD_SIZE-1:0]     mem_rdata_i,
   output logic                     mem_req_o,
   output logic                     mem_we_o,
   output logic                     mem_io_o,
   input  logic                     mem_ack_i,
   input  logic                     irq_i,
   output logic                     irq_ack_o,
   output logic [2:0]               state_o
);

   // Register-index width; upper register-field bits are ignored when
   // NUM_REGS < 16.
   localparam int c_RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   localparam logic [WORD_SIZE-1:0] c_LO_MASK = WORD_SIZE'(16'h00FF);
   localparam logic [WORD_SIZE-1:0] c_HI_MASK = WORD_SIZE'(16'hFF00);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_IRQ    = 3'd5
   } state_t;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_t                     state_q;
   logic [15:0]                ir_q;
   logic [INS_ADDR_SIZE-1:0]   pc_q;
   logic [INS_ADDR_SIZE-1:0]   epc_q;
   logic                       ie_q;
   logic [WORD_SIZE-1:0]       regs_q [NUM_REGS];
   logic [WORD_SIZE-1:0]       rav_q;      // ra operand (STORE data, LOADLO/HI base)
   logic [WORD_SIZE-1:0]       rbv_q;
   logic [WORD_SIZE-1:0]       rcv_q;
   logic [WORD_SIZE-1:0]       result_q;   // ALU result, or load data after MEM
   logic [WORD_SIZE-1:0]       addr_q;
   logic [INS_ADDR_SIZE-1:0]   npc_q;

   // -------------------------------------------------------------------------
   // Instruction field decode (from the latched instruction)
   // -------------------------------------------------------------------------
   logic [3:0]                 w_op;
   logic [3:0]                 w_ra_field;
   logic [c_RIDX_W-1:0]        w_ra;
   logic [c_RIDX_W-1:0]        w_rb;
   logic [c_RIDX_W-1:0]        w_rc;
   logic [7:0]                 w_imm8;
   logic [3:0]                 w_imm4;
   logic                       w_is_mem;
   logic                       w_is_we;
   logic                       w_is_io;
   logic                       w_wr_en;
   logic                       w_is_iret;

   assign w_op       = ir_q[15:12];
   assign w_ra_field = ir_q[11:8];
   assign w_ra       = ir_q[8 +: c_RIDX_W];
   assign w_rb       = ir_q[4 +: c_RIDX_W];
   assign w_rc       = ir_q[0 +: c_RIDX_W];
   assign w_imm8     = ir_q[7:0];
   assign w_imm4     = ir_q[3:0];

   // A LOAD, B STORE, C IN, D OUT
   assign w_is_mem  = (w_op >= 4'hA) && (w_op <= 4'hD);
   assign w_is_we   = (w_op == 4'hB) || (w_op == 4'hD);
   assign w_is_io   = (w_op == 4'hC) || (w_op == 4'hD);
   // Register write-back for ALU ops, LOADLO/HI, LOAD and IN
   assign w_wr_en   = (w_op <= 4'hA) || (w_op == 4'hC);
   assign w_is_iret = (w_op == 4'hF) && (w_ra_field == 4'hF);

   // -------------------------------------------------------------------------
   // Execute-stage datapath
   // -------------------------------------------------------------------------
   logic [WORD_SIZE-1:0]       result_d;
   logic [WORD_SIZE-1:0]       addr_d;
   logic [INS_ADDR_SIZE-1:0]   npc_d;
   logic [INS_ADDR_SIZE-1:0]   w_off;
   logic [INS_ADDR_SIZE-1:0]   w_pc_inc;
   logic [INS_ADDR_SIZE-1:0]   w_pc_rel;

   // Sign-extend imm8 to 32 bits, then fold to the pc width so that pc
   // arithmetic wraps naturally.
   assign w_off    = INS_ADDR_SIZE'({{24{w_imm8[7]}}, w_imm8});
   assign w_pc_inc = pc_q + INS_ADDR_SIZE'(1);
   assign w_pc_rel = pc_q + w_off;

   always_comb begin
      result_d = rav_q;
      case (w_op)
         4'h0:    result_d = rbv_q + rcv_q;
         4'h1:    result_d = rbv_q - rcv_q;
         4'h2:    result_d = rbv_q & rcv_q;
         4'h3:    result_d = rbv_q | rcv_q;
         4'h4:    result_d = rbv_q ^ rcv_q;
         4'h5:    result_d = rbv_q << rcv_q[3:0];
         4'h6:    result_d = rbv_q >> rcv_q[3:0];
         4'h7:    result_d = ~rbv_q;
         4'h8:    result_d = (rav_q & ~c_LO_MASK) | WORD_SIZE'(w_imm8);
         4'h9:    result_d = (rav_q & ~c_HI_MASK) | (WORD_SIZE'(w_imm8) << 8);
         default: result_d = rav_q;
      endcase
   end

   assign addr_d = rbv_q + WORD_SIZE'(w_imm4);

   always_comb begin
      npc_d = w_pc_inc;
      if (w_op == 4'hE) begin
         npc_d = (rav_q != '0) ? w_pc_rel : w_pc_inc;
      end else if (w_op == 4'hF) begin
         npc_d = w_is_iret ? epc_q : w_pc_rel;
      end
   end

   // -------------------------------------------------------------------------
   // Control FSM and architectural state
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= S_FETCH;
         ir_q     <= '0;
         pc_q     <= '0;
         epc_q    <= '0;
         ie_q     <= 1'b1;
         rav_q    <= '0;
         rbv_q    <= '0;
         rcv_q    <= '0;
         result_q <= '0;
         addr_q   <= '0;
         npc_q    <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         case (state_q)
            S_FETCH: begin
               if (ins_ack_i) begin
                  ir_q    <= ins_data_i;
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               rav_q   <= regs_q[w_ra];
               rbv_q   <= regs_q[w_rb];
               rcv_q   <= regs_q[w_rc];
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               result_q <= result_d;
               addr_q   <= addr_d;
               npc_q    <= npc_d;
               state_q  <= w_is_mem ? S_MEM : S_WB;
            end
            S_MEM: begin
               // Address/data/direction come from registers that do not
               // change here, so they stay stable for the whole wait.
               if (mem_ack_i) begin
                  result_q <= mem_rdata_i;
                  state_q  <= S_WB;
               end
            end
            S_WB: begin
               if (w_wr_en) begin
                  regs_q[w_ra] <= result_q;
               end
               pc_q <= npc_q;
               if (w_is_iret) begin
                  ie_q <= 1'b1;
               end
               // ie_q here is the pre-IRET value, so an IRET never
               // re-enters on its own write-back.
               state_q <= (irq_i && ie_q) ? S_IRQ : S_FETCH;
            end
            S_IRQ: begin
               epc_q   <= pc_q;
               ie_q    <= 1'b0;
               pc_q    <= IRQ_VECTOR;
               state_q <= S_FETCH;
            end
            default: begin
               state_q <= S_FETCH;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: decoded from registered state; handshake strobes are masked
   // by reset so they drop in the same cycle reset is asserted.
   // -------------------------------------------------------------------------
   logic w_in_mem;
   assign w_in_mem = (state_q == S_MEM) && !reset_i;

   assign ins_addr_o  = pc_q;
   assign ins_req_o   = (state_q == S_FETCH) && !reset_i;
   assign mem_req_o   = w_in_mem;
   assign mem_we_o    = w_in_mem && w_is_we;
   assign mem_io_o    = w_in_mem && w_is_io;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = rav_q;
   assign irq_ack_o   = (state_q == S_IRQ) && !reset_i;
   assign state_o     = state_q;

endmodule
`default_nettype wire
